// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction register and runs one memory read per fetch.
// Optional completed-fetch counter is enabled by defining IFU_FETCH_COUNT_EN.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 26,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 26'h0001000,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FETCH_START,
    input  logic              PC_UPDATE,
    input  logic [1:0]        PC_SEL,
    input  logic [15:0]       BRANCH_OFF,
    input  logic [ADDR_W-1:0] JUMP_ADDR,
    input  logic [31:0]       REG_TARGET,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_READ,
    input  logic              MEM_READY,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [DATA_W-1:0] INSTRUCTION,
    output logic              INSTR_VALID,
    output logic              BUSY,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_PLUS1,
    output logic              FAULT,
    output logic [31:0]       FETCH_COUNT
);

    // state | meaning
    // IDLE  | waiting for FETCH_START; PC updates apply immediately
    // REQ   | read issued at PC; ready here completes in minimum latency
    // WAIT  | read held until MEM_READY or TIMEOUT wait cycles elapse
    // DONE  | INSTR_VALID pulse; pending PC update applied on exit
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam int unsigned       EXT_W    = ADDR_W - 16;

    state_t            state;
    logic [CNT_W-1:0]  timeout_cnt;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] upd_pc;
    logic [ADDR_W-1:0] branch_ext;
    logic              unused_reg_bits;

    assign PC_PLUS1        = PC + PC_ONE;
    assign branch_ext      = {{EXT_W{BRANCH_OFF[15]}}, BRANCH_OFF};
    assign unused_reg_bits = &{1'b0, REG_TARGET[31:ADDR_W]};

    always_comb begin
        upd_pc = PC_PLUS1;
        case (PC_SEL)
            2'b01:   upd_pc = PC_PLUS1 + branch_ext;
            2'b10:   upd_pc = JUMP_ADDR;
            2'b11:   upd_pc = REG_TARGET[ADDR_W-1:0];
            default: upd_pc = PC_PLUS1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            PC          <= RESET_PC;
            INSTRUCTION <= '0;
            MEM_READ    <= 1'b0;
            MEM_ADDR    <= '0;
            INSTR_VALID <= 1'b0;
            BUSY        <= 1'b0;
            FAULT       <= 1'b0;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            timeout_cnt <= '0;
        end else begin
            INSTR_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (PC_UPDATE) begin
                        PC <= upd_pc;
                    end
                    if (FETCH_START) begin
                        state       <= S_REQ;
                        MEM_READ    <= 1'b1;
                        MEM_ADDR    <= PC_UPDATE ? upd_pc : PC;
                        BUSY        <= 1'b1;
                        timeout_cnt <= '0;
                    end
                end
                S_REQ, S_WAIT: begin
                    // PC stays frozen mid-fetch, so the target can be resolved now
                    if (PC_UPDATE) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= upd_pc;
                    end
                    if (MEM_READY) begin
                        INSTRUCTION <= MEM_DATA;
                        state       <= S_DONE;
                        MEM_READ    <= 1'b0;
                        BUSY        <= 1'b0;
                        INSTR_VALID <= 1'b1;
                    end else if (state == S_REQ) begin
                        state       <= S_WAIT;
                        timeout_cnt <= '0;
                    end else if (timeout_cnt == TMO_LAST) begin
                        INSTRUCTION <= '0;
                        FAULT       <= 1'b1;
                        state       <= S_DONE;
                        MEM_READ    <= 1'b0;
                        BUSY        <= 1'b0;
                        INSTR_VALID <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    pend_valid <= 1'b0;
                    if (PC_UPDATE) begin
                        PC <= upd_pc;
                    end else if (pend_valid) begin
                        PC <= pend_pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] fetch_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_cnt <= '0;
        end else if (INSTR_VALID) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign FETCH_COUNT = fetch_cnt;
`else
    assign FETCH_COUNT = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: PC arithmetic table, directed fetch sequences,
// and randomized fetches checked against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int          AW  = 26;
    localparam int          DW  = 32;
    localparam int          TMO = 15;
    localparam logic [25:0] RPC = 26'h0001000;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          FETCH_START = 1'b0;
    logic          PC_UPDATE = 1'b0;
    logic [1:0]    PC_SEL = 2'b00;
    logic [15:0]   BRANCH_OFF = '0;
    logic [AW-1:0] JUMP_ADDR = '0;
    logic [31:0]   REG_TARGET = '0;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_READ;
    logic          MEM_READY = 1'b0;
    logic [DW-1:0] MEM_DATA = '0;
    logic [DW-1:0] INSTRUCTION;
    logic          INSTR_VALID;
    logic          BUSY;
    logic [AW-1:0] PC;
    logic [AW-1:0] PC_PLUS1;
    logic          FAULT;
    logic [31:0]   FETCH_COUNT;

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .FETCH_START(FETCH_START), .PC_UPDATE(PC_UPDATE),
        .PC_SEL(PC_SEL), .BRANCH_OFF(BRANCH_OFF), .JUMP_ADDR(JUMP_ADDR),
        .REG_TARGET(REG_TARGET), .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ),
        .MEM_READY(MEM_READY), .MEM_DATA(MEM_DATA), .INSTRUCTION(INSTRUCTION),
        .INSTR_VALID(INSTR_VALID), .BUSY(BUSY), .PC(PC), .PC_PLUS1(PC_PLUS1),
        .FAULT(FAULT), .FETCH_COUNT(FETCH_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [25:0] m_pc = RPC;
    bit          m_fault = 0;
    int unsigned m_cnt = 0;
    bit          m_pend = 0;
    logic [25:0] m_pend_pc = '0;

    typedef struct {
        logic [25:0] start_pc;
        logic [1:0]  sel;
        logic [15:0] off;
        logic [25:0] jmp;
        logic [31:0] rt;
        logic [25:0] exp_pc;
        logic [25:0] exp_p1;
    } pc_vec_t;

    pc_vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Next-PC rule evaluated as plain integer arithmetic modulo 2^26
    function automatic logic [25:0] calc_pc(input logic [25:0] pc, input logic [1:0] sel,
                                            input logic [15:0] off, input logic [25:0] jmp,
                                            input logic [31:0] rt);
        longint t;
        case (sel)
            2'd0:    t = longint'(pc) + 1;
            2'd1:    t = longint'(pc) + 1 + longint'($signed(off));
            2'd2:    t = longint'(jmp);
            default: t = longint'(rt);
        endcase
        t = t % 67108864;
        if (t < 0) t = t + 67108864;
        return 26'(t);
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef IFU_FETCH_COUNT_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic rand_upd(output logic [25:0] tgt);
        PC_UPDATE  = 1'b1;
        PC_SEL     = 2'($urandom_range(0, 3));
        BRANCH_OFF = 16'($urandom);
        JUMP_ADDR  = 26'($urandom);
        REG_TARGET = $urandom;
        tgt = calc_pc(m_pc, PC_SEL, BRANCH_OFF, JUMP_ADDR, REG_TARGET);
    endtask

    task automatic clr_inputs();
        FETCH_START = 1'b0;
        PC_UPDATE   = 1'b0;
        MEM_READY   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, INSTR_VALID, 1'b0);
        chk({tag, "_busy"}, BUSY, 1'b0);
        chk({tag, "_read"}, MEM_READ, 1'b0);
        chk({tag, "_pc"}, PC, m_pc);
        chk({tag, "_pc_plus1"}, PC_PLUS1, calc_pc(m_pc, 2'd0, 16'd0, 26'd0, 32'd0));
        chk({tag, "_fault"}, FAULT, m_fault);
        chk({tag, "_count"}, FETCH_COUNT, exp_cnt());
    endtask

    // k = number of wait cycles before MEM_READY (0 = ready in REQ); plan_w forces a jump in that busy cycle
    task automatic do_fetch(input int k, input logic [31:0] data, input int plan_w,
                            input logic [25:0] plan_jmp, input bit same_upd, input bit rnd);
        logic [25:0] tgt;
        logic [25:0] fpc;
        logic [31:0] exp_instr;
        int          lat;
        int          exp_lat;
        bit          got;
        m_pend = 0;
        FETCH_START = 1'b1;
        if (same_upd) begin
            rand_upd(tgt);
            m_pc = tgt;
        end
        step();
        clr_inputs();
        fpc = m_pc;
        chk("req_read", MEM_READ, 1'b1);
        chk("req_addr", MEM_ADDR, fpc);
        chk("req_busy", BUSY, 1'b1);
        chk("req_valid", INSTR_VALID, 1'b0);
        got = 0;
        lat = 0;
        for (int w = 0; w <= TMO + 4 && !got; w++) begin
            MEM_READY = (w == k);
            MEM_DATA  = (w == k) ? data : $urandom;
            if (w == plan_w) begin
                PC_UPDATE = 1'b1;
                PC_SEL    = 2'b10;
                JUMP_ADDR = plan_jmp;
                m_pend    = 1;
                m_pend_pc = plan_jmp;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                rand_upd(tgt);
                m_pend    = 1;
                m_pend_pc = tgt;
            end
            if (rnd) FETCH_START = 1'($urandom_range(0, 1));
            step();
            clr_inputs();
            if (INSTR_VALID === 1'b1) begin
                got = 1;
                lat = w + 2;
            end else begin
                chk("wait_read", MEM_READ, 1'b1);
                chk("wait_addr", MEM_ADDR, fpc);
                chk("wait_busy", BUSY, 1'b1);
                chk("wait_pc", PC, fpc);
            end
        end
        exp_lat   = 2 + ((k <= TMO) ? k : TMO);
        exp_instr = (k <= TMO) ? data : 32'd0;
        if (k > TMO) m_fault = 1;
        chk("valid_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("done_instr", INSTRUCTION, exp_instr);
        chk("done_fault", FAULT, m_fault);
        chk("done_busy", BUSY, 1'b0);
        chk("done_read", MEM_READ, 1'b0);
        chk("done_pc", PC, fpc);
        m_cnt++;
        if (rnd) begin
            FETCH_START = 1'($urandom_range(0, 1));
            MEM_READY   = 1'($urandom_range(0, 1));
            if (!m_pend && $urandom_range(0, 2) == 0) begin
                rand_upd(tgt);
                m_pc = tgt;
            end
        end
        step();
        clr_inputs();
        if (m_pend) m_pc = m_pend_pc;
        m_pend = 0;
        chk_idle("post");
    endtask

    initial begin
        logic [25:0] tgt;
        tbl[0] = '{26'h0001005, 2'b01, 16'hFFFD, 26'h0,       32'h0,         26'h0001003, 26'h0001004};
        tbl[1] = '{26'h0001005, 2'b10, 16'h0,    26'h0002000, 32'h0,         26'h0002000, 26'h0002001};
        tbl[2] = '{26'h0001005, 2'b11, 16'h0,    26'h0,       32'hFC00_0010, 26'h0000010, 26'h0000011};
        tbl[3] = '{26'h3FFFFFF, 2'b00, 16'h0,    26'h0,       32'h0,         26'h0000000, 26'h0000001};
        tbl[4] = '{26'h0000010, 2'b01, 16'h7FFF, 26'h0,       32'h0,         26'h0008010, 26'h0008011};
        tbl[5] = '{26'h0000000, 2'b01, 16'h8000, 26'h0,       32'h0,         26'h3FF8001, 26'h3FF8002};
        tbl[6] = '{26'h3FFFFFE, 2'b00, 16'h0,    26'h0,       32'h0,         26'h3FFFFFF, 26'h0000000};

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        chk("rst_pc", PC, RPC);
        chk("rst_instr", INSTRUCTION, 32'd0);
        chk("rst_addr", MEM_ADDR, 26'd0);
        chk_idle("rst");

        do_fetch(0, 32'h20220005, -1, '0, 0, 0);
        chk("first_instr", INSTRUCTION, 32'h20220005);
        do_fetch(3, 32'hDEADBEEF, -1, '0, 0, 0);
        do_fetch(TMO + 3, 32'h12345678, -1, '0, 0, 0);
        do_fetch(TMO, 32'hCAFEF00D, -1, '0, 0, 0);
        do_fetch(3, 32'h0BADF00D, 1, 26'h0000100, 0, 0);
        chk("jump_during_wait", PC, 26'h0000100);

        foreach (tbl[i]) begin
            PC_UPDATE = 1'b1;
            PC_SEL    = 2'b10;
            JUMP_ADDR = tbl[i].start_pc;
            step();
            PC_SEL     = tbl[i].sel;
            BRANCH_OFF = tbl[i].off;
            JUMP_ADDR  = tbl[i].jmp;
            REG_TARGET = tbl[i].rt;
            step();
            PC_UPDATE = 1'b0;
            chk($sformatf("tbl%0d_pc", i), PC, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_plus1", i), PC_PLUS1, tbl[i].exp_p1);
            m_pc = tbl[i].exp_pc;
        end

        do_fetch(0, 32'h11110000, -1, '0, 1, 0);
        do_fetch(2, 32'h22220000, -1, '0, 1, 0);

        FETCH_START = 1'b1;
        step();
        FETCH_START = 1'b0;
        step();
        PC_UPDATE = 1'b1;
        PC_SEL    = 2'b10;
        JUMP_ADDR = 26'h0000123;
        step();
        PC_UPDATE = 1'b0;
        chk("pre_rst_read", MEM_READ, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_read", MEM_READ, 1'b0);
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_pc", PC, RPC);
        chk("arst_fault", FAULT, 1'b0);
        chk("arst_addr", MEM_ADDR, 26'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        m_pc = RPC;
        m_fault = 0;
        m_cnt = 0;
        m_pend = 0;
        repeat (4) begin
            step();
            chk_idle("after_rst");
        end

        do_fetch(0, 32'hA0000001, -1, '0, 0, 0);
        do_fetch(1, 32'hA0000002, -1, '0, 0, 0);
        do_fetch(TMO + 1, 32'hA0000003, -1, '0, 0, 0);
        chk("fetch_count3", FETCH_COUNT, exp_cnt());

        for (int op = 0; op < 80; op++) begin
            if ($urandom_range(0, 2) == 0) begin
                MEM_READY = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin
                    rand_upd(tgt);
                    m_pc = tgt;
                end
                step();
                clr_inputs();
                chk_idle("rnd_idle");
            end else begin
                do_fetch(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 3))
                                                     : int'($urandom_range(0, 3)),
                         $urandom, -1, '0, 1'($urandom_range(0, 1)), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
